// File: rtl/hand_tracker_if.sv
// Play handshake between a player and the hand tracker.
// A play transfers on a rising clk edge where play_valid and play_ready are
// both 1; play_card is only meaningful in that cycle. The tracker answers with
// a one-cycle accept or reject pulse in the cycle after the transfer.
interface hand_tracker_if;
    logic       play_valid;
    logic [3:0] play_card;
    logic       play_ready;
    logic       accept;
    logic       reject;

    modport master (
        output play_valid,
        output play_card,
        input  play_ready,
        input  accept,
        input  reject
    );

    modport slave (
        input  play_valid,
        input  play_card,
        output play_ready,
        output accept,
        output reject
    );
endinterface

// File: rtl/hand_tracker.sv
// Hand tracker for a nine-card game (cards 0..8).
// Keeps the mask of cards still held, checks each offered play against it,
// reports accept/reject for one cycle and counts accepted plays up to 9.
module hand_tracker (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    hand_tracker_if.slave        play_if,
    output logic [8:0]           p_card_o,
    output logic [3:0]           card_out_o,
    output logic                 card_color_o,
    output logic [3:0]           round_o,
    output logic                 done_o,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_RESULT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] p_card_q, p_card_d;
    logic [3:0] round_q, round_d;
    logic [3:0] card_out_q, card_out_d;
    logic       card_color_q, card_color_d;
    logic       accept_q, accept_d;
    logic       reject_q, reject_d;

    // One-hot mask of the offered card; shifting past bit 8 yields zero,
    // so out-of-range cards never match a held card.
    logic [8:0] card_mask;
    logic       play_legal;

    // Legality of the offered card against the current hand.
    always_comb begin
        card_mask  = 9'h001 << play_if.play_card;
        play_legal = (play_if.play_card <= 4'd8) && (|(p_card_q & card_mask));
    end

    // Next-state and datapath updates; start overrides any play.
    always_comb begin
        state_d      = state_q;
        p_card_d     = p_card_q;
        round_d      = round_q;
        card_out_d   = card_out_q;
        card_color_d = card_color_q;
        accept_d     = 1'b0;
        reject_d     = 1'b0;

        if (start_i) begin
            state_d  = S_WAIT;
            p_card_d = 9'h1FF;
            round_d  = 4'd0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (play_if.play_valid) begin
                        state_d = S_RESULT;
                        if (play_legal) begin
                            p_card_d     = p_card_q & ~card_mask;
                            round_d      = (round_q >= 4'd9) ? 4'd9 : round_q + 4'd1;
                            card_out_d   = play_if.play_card;
                            card_color_d = play_if.play_card[0];
                            accept_d     = 1'b1;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end
                end
                S_RESULT: begin
                    state_d = (round_q == 4'd9) ? S_DONE : S_WAIT;
                end
                default: begin
                    // IDLE and DONE hold until start or reset.
                    state_d = state_q;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            p_card_q     <= 9'h000;
            round_q      <= 4'd0;
            card_out_q   <= 4'd0;
            card_color_q <= 1'b0;
            accept_q     <= 1'b0;
            reject_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_card_q     <= p_card_d;
            round_q      <= round_d;
            card_out_q   <= card_out_d;
            card_color_q <= card_color_d;
            accept_q     <= accept_d;
            reject_q     <= reject_d;
        end
    end

    // Outputs decoded straight from registers so they change only at edges or reset.
    always_comb begin
        play_if.play_ready = (state_q == S_WAIT);
        play_if.accept     = accept_q;
        play_if.reject     = reject_q;
        p_card_o           = p_card_q;
        card_out_o         = card_out_q;
        card_color_o       = card_color_q;
        round_o            = round_q;
        done_o             = (state_q == S_DONE);
        state_o            = state_q;
    end

endmodule
